// File: rtl/fetch_predecode_queue_pkg.sv
// Shared types for the fetch pre-decode queue.
// Instruction word, opcode constants, link-register ids and the PD_SLOT record.
package fetch_predecode_queue_pkg;

  typedef logic [31:0] INST;

  localparam logic [6:0] RV32_BRANCH = 7'b1100011;
  localparam logic [6:0] RV32_JAL    = 7'b1101111;
  localparam logic [6:0] RV32_JALR   = 7'b1100111;

  localparam logic [4:0] RA_X1 = 5'd1;
  localparam logic [4:0] RA_X5 = 5'd5;

  typedef struct packed {
    logic        valid;
    INST         inst;
    logic [31:0] pc;
    logic        cond_branch;
    logic        uncond_branch;
    logic        jump;
    logic        link;
    logic        call;
    logic        ret;
    logic [31:0] target;
  } PD_SLOT;

  function automatic logic is_ra(input logic [4:0] r);
    return (r == RA_X1) || (r == RA_X5);
  endfunction

endpackage

// File: rtl/fetch_predecode_queue_slot.sv
// Combinational pre-decoder for one fetch slot.
// Ports: valid/inst/pc in, one PD_SLOT record out.
module predecode_slot
  import fetch_predecode_queue_pkg::*;
(
  input  logic        valid,
  input  INST         inst,
  input  logic [31:0] pc,
  output PD_SLOT      slot
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_br;
  logic        is_jal;
  logic        is_jalr;
  logic        is_call;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];

  assign b_imm = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  // funct3 010/011 are not defined branch encodings
  assign is_br   = valid && (opc == RV32_BRANCH) &&
                   (f3 != 3'b010) && (f3 != 3'b011);
  assign is_jal  = valid && (opc == RV32_JAL);
  assign is_jalr = valid && (opc == RV32_JALR) && (f3 == 3'b000);
  assign is_call = (is_jal || is_jalr) && is_ra(rd);

  always_comb begin
    slot               = '0;
    slot.valid         = valid;
    slot.inst          = inst;
    slot.pc            = pc;
    slot.cond_branch   = is_br;
    slot.uncond_branch = is_jal || is_jalr;
    slot.jump          = is_jal;
    slot.link          = is_jalr;
    slot.call          = is_call;
    slot.ret           = is_jalr && (rd == 5'd0) &&
                         is_ra(rs1) && !is_call;
    unique case (1'b1)
      is_br:   slot.target = pc + b_imm;
      is_jal:  slot.target = pc + j_imm;
      default: slot.target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_predecode_queue.sv
// Multi-slot pre-decoder with JAL truncation, fetch redirect and bundle FIFO.
// Ports: clock/reset/flush, in_* bundle + in_ready, out_* head + out_ready, redirect_*, count.
module fetch_predecode_queue
  import fetch_predecode_queue_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_valid,
  input  INST  [WIDTH-1:0]           in_inst,
  input  logic [31:0]                in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output PD_SLOT [WIDTH-1:0]         out_bundle,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  PD_SLOT [WIDTH-1:0] dec;
  PD_SLOT [WIDTH-1:0] kept;
  logic               hit;
  logic [31:0]        hit_tgt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slot
    predecode_slot u_slot (
      .valid (in_valid[i]),
      .inst  (in_inst[i]),
      .pc    (in_pc + 32'(4 * i)),
      .slot  (dec[i])
    );
  end

  // Slots after the first valid JAL are dead: keep inst/pc, drop the rest
  always_comb begin
    kept    = dec;
    hit     = 1'b0;
    hit_tgt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (hit) begin
        kept[i]      = '0;
        kept[i].inst = dec[i].inst;
        kept[i].pc   = dec[i].pc;
      end else if (dec[i].jump) begin
        hit     = 1'b1;
        hit_tgt = dec[i].target;
      end
    end
  end

  PD_SLOT [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic               push;
  logic               pop;

  assign in_ready   = count < FULL;
  assign out_valid  = count != '0;
  assign push       = (|in_valid) && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_bundle = mem[head];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= kept;
        tail      <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= push && hit;
      if (push && hit) redirect_pc <= hit_tgt;
    end
  end

endmodule
